gpr_xfer_ctrl: RTL

GPR_XFER_CTRL -- requirements
Module: gpr_xfer_ctrl

---
 rtl/gpr_xfer_pkg.sv | 39 +++
 rtl/gpr_xfer_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gpr_xfer_pkg.sv
// Shared types for the GPR transfer controller: op codes, FSM states, GPR_select encodings.
// Build option: define GPR_XFER_SWAP_EN to enable the SWAP command.
package gpr_xfer_pkg;

  localparam int unsigned DataW = 16;

  typedef enum logic [1:0] {
    OpMove  = 2'b00,
    OpSwap  = 2'b01,
    OpClear = 2'b10,
    OpRsvd  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdB  = 3'd2,
    StWrA  = 3'd3,
    StWrB  = 3'd4,
    StClr  = 3'd5,
    StFin  = 3'd6
  } state_e;

  localparam logic [2:0] SelR0  = 3'b000;
  localparam logic [2:0] SelR7  = 3'b001;
  localparam logic [2:0] SelRd1 = 3'b010;
  localparam logic [2:0] SelRd2 = 3'b011;
  localparam logic [2:0] SelRs1 = 3'b100;
  localparam logic [2:0] SelRs2 = 3'b101;

  function automatic logic op_legal(op_e op);
`ifdef GPR_XFER_SWAP_EN
    return op != OpRsvd;
`else
    return (op == OpMove) || (op == OpClear);
`endif
  endfunction

endpackage

// File: rtl/gpr_xfer_ctrl.sv
// Register-to-register transfer controller sequencing MOVE/SWAP/CLEAR over a shared DATA bus.
// Build option: GPR_XFER_SWAP_EN adds SWAP (RD_B/WR_B states and the second holding register).
module gpr_xfer_ctrl
  import gpr_xfer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  inout  wire  [DataW-1:0] DATA,
  output logic             GPR_in,
  output logic             GPR_out,
  output logic [2:0]       GPR_select,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_src,
  input  logic [2:0]       cmd_dst,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [2:0]       src_q, dst_q;
  logic [DataW-1:0] tmp_a_q;
  logic             err_q, err_d;
  logic             drive_en;
  logic [DataW-1:0] drive_val;
  logic             accept;
`ifdef GPR_XFER_SWAP_EN
  logic [DataW-1:0] tmp_b_q;
`endif

  assign accept = cmd_valid && cmd_ready;
  assign err    = err_q;
  assign DATA   = drive_en ? drive_val : {DataW{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpMove;
      src_q   <= SelR0;
      dst_q   <= SelR0;
      tmp_a_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        src_q <= cmd_src;
        dst_q <= cmd_dst;
      end
      if (state_q == StRdA) tmp_a_q <= DATA;
    end
  end

`ifdef GPR_XFER_SWAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmp_b_q <= '0;
    end else if (state_q == StRdB) begin
      tmp_b_q <= DATA;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    GPR_in     = 1'b0;
    GPR_out    = 1'b0;
    GPR_select = SelR0;
    drive_en   = 1'b0;
    drive_val  = '0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // Illegal ops stay in IDLE; the registered err pulse appears next cycle.
          if (!op_legal(op_e'(cmd_op))) begin
            err_d = 1'b1;
          end else if (op_e'(cmd_op) == OpClear) begin
            state_d = StClr;
          end else begin
            state_d = StRdA;
          end
        end
      end
      StRdA: begin
        GPR_out    = 1'b1;
        GPR_select = src_q;
`ifdef GPR_XFER_SWAP_EN
        state_d    = (op_q == OpSwap) ? StRdB : StWrA;
`else
        state_d    = StWrA;
`endif
      end
`ifdef GPR_XFER_SWAP_EN
      StRdB: begin
        GPR_out    = 1'b1;
        GPR_select = dst_q;
        state_d    = StWrA;
      end
`endif
      StWrA: begin
        GPR_in     = 1'b1;
        GPR_select = dst_q;
        drive_en   = 1'b1;
        drive_val  = tmp_a_q;
`ifdef GPR_XFER_SWAP_EN
        state_d    = (op_q == OpSwap) ? StWrB : StFin;
`else
        state_d    = StFin;
`endif
      end
`ifdef GPR_XFER_SWAP_EN
      StWrB: begin
        GPR_in     = 1'b1;
        GPR_select = src_q;
        drive_en   = 1'b1;
        drive_val  = tmp_b_q;
        state_d    = StFin;
      end
`endif
      StClr: begin
        GPR_in     = 1'b1;
        GPR_select = dst_q;
        drive_en   = 1'b1;
        state_d    = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
